gray_step_tracker: RTL and testbench

GRAY_STEP_TRACKER -- requirements
Module: gray_step_tracker

---
 rtl/gray_step_tracker.sv | 177 +++++++++++++++++
 tb/tb_gray_step_tracker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_tracker.sv
// gray_step_tracker
//
// Follows a 2-bit Gray-coded position input that is asynchronous to clk.
// It keeps a wrapping position count, pulses step on each legal move,
// remembers the direction of the last move, and flags illegal double-bit
// jumps with a sticky error plus a saturating error count.
//
// Ports
//   clk      in   single clock, rising edge
//   res      in   synchronous active-high reset
//   gray_in  in   [1:0] Gray code from upstream (asynchronous)
//   clr_err  in   synchronous clear of err / err_cnt
//   pos      out  [POS_W-1:0] position, wraps modulo 2^POS_W
//   step     out  one-cycle pulse per legal transition
//   dir      out  1 = last legal step forward, 0 = backward
//   err      out  sticky illegal-transition flag
//   err_cnt  out  [3:0] illegal-transition count, saturates at 15
//
// state  | meaning
// WARMUP | synchroniser filling after reset; no step/err generated
// TRACK  | comparing synchronised input against prev each cycle

module gray_step_tracker #(
    parameter int POS_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic [1:0]       gray_in,
    input  logic             clr_err,
    output logic [POS_W-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [3:0]       err_cnt
);

    typedef enum logic {
        WARMUP = 1'b0,
        TRACK  = 1'b1
    } state_t;

    // Holds up to SYNC_STAGES-1 for the legal range 2..4.
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(SYNC_STAGES - 1);

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][1:0]   sync_q, sync_d;
    logic [CNT_W-1:0]              warm_q, warm_d;
    logic [1:0]                    prev_q, prev_d;
    logic [POS_W-1:0]              pos_q, pos_d;
    logic                          step_q, step_d;
    logic                          dir_q, dir_d;
    logic                          err_q, err_d;
    logic [3:0]                    err_cnt_q, err_cnt_d;

    logic [1:0] sync_out;
    logic [1:0] diff;
    logic       is_fwd;
    logic       is_illegal;
    logic       is_back;

    // Forward successor in the sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] gray_fwd(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign diff       = sync_out ^ prev_q;
    assign is_fwd     = (sync_out == gray_fwd(prev_q));
    assign is_illegal = (diff == 2'b11);
    assign is_back    = (diff != 2'b00) && !is_fwd && !is_illegal;

    always_comb begin
        // Stage 0 takes the raw input; the last stage is the only one used.
        sync_d    = {sync_q[SYNC_STAGES-2:0], gray_in};
        state_d   = state_q;
        warm_d    = warm_q;
        prev_d    = prev_q;
        pos_d     = pos_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            WARMUP: begin
                if (warm_q == '0) begin
                    state_d = TRACK;
                    // Baseline is the value sync_out takes at this edge, so
                    // an input held steady through reset and warm-up is
                    // already the reference on the first TRACK cycle.
                    prev_d  = sync_d[SYNC_STAGES-1];
                end else begin
                    warm_d = warm_q - 1'b1;
                end
                if (clr_err) begin
                    err_d     = 1'b0;
                    err_cnt_d = 4'd0;
                end
            end

            TRACK: begin
                if (is_illegal) begin
                    // Resynchronise to whatever arrived; a clear in the same
                    // cycle still leaves this one error recorded.
                    prev_d = sync_out;
                    err_d  = 1'b1;
                    if (clr_err) begin
                        err_cnt_d = 4'd1;
                    end else if (err_cnt_q != 4'd15) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
                end else begin
                    if (clr_err) begin
                        err_d     = 1'b0;
                        err_cnt_d = 4'd0;
                    end
                    if (is_fwd) begin
                        pos_d  = pos_q + POS_W'(1);
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                        prev_d = sync_out;
                    end else if (is_back) begin
                        pos_d  = pos_q - POS_W'(1);
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                        prev_d = sync_out;
                    end
                end
            end

            default: begin
                state_d = WARMUP;
                warm_d  = WARM_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= WARMUP;
            sync_q    <= '0;
            warm_q    <= WARM_LOAD;
            prev_q    <= 2'b00;
            pos_q     <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            err_q     <= 1'b0;
            err_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            warm_q    <= warm_d;
            prev_q    <= prev_d;
            pos_q     <= pos_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pos     = pos_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
module tb_gray_step_tracker;

    localparam int POS_W = 8;
    localparam int SS    = 2;

    logic             clk;
    logic             res;
    logic [1:0]       gray_in;
    logic             clr_err;
    logic [POS_W-1:0] pos;
    logic             step;
    logic             dir;
    logic             err;
    logic [3:0]       err_cnt;

    int total = 0;
    int bad   = 0;

    gray_step_tracker #(.POS_W(POS_W), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .res     (res),
        .gray_in (gray_in),
        .clr_err (clr_err),
        .pos     (pos),
        .step    (step),
        .dir     (dir),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference ----------------
    // The synchroniser is modelled as a plain delay line of input samples;
    // moves are classified by the distance between Gray positions mod 4.
    logic [1:0]  m_pipe[$];
    logic        m_valid = 1'b0;
    int          m_warm;
    logic [1:0]  m_prev;
    int          m_pos;
    logic        m_step;
    logic        m_dir;
    logic        m_err;
    int          m_cnt;
    logic [1:0]  m_seen;
    int          m_delta;
    int          cyc_no = 0;

    function automatic int gidx(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc_no++;
        if (res) begin
            m_pipe.delete();
            for (int i = 0; i < SS; i++) m_pipe.push_back(2'b00);
            m_warm  = SS;
            m_prev  = 2'b00;
            m_pos   = 0;
            m_step  = 1'b0;
            m_dir   = 1'b1;
            m_err   = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_seen = m_pipe[SS-1];           // sample taken SS edges ago
            m_pipe.push_front(gray_in);
            void'(m_pipe.pop_back());
            m_step = 1'b0;
            if (m_warm > 0) begin
                m_warm--;
                if (m_warm == 0) m_prev = m_pipe[SS-1];
                if (clr_err) begin
                    m_err = 1'b0;
                    m_cnt = 0;
                end
            end else begin
                m_delta = (gidx(m_seen) - gidx(m_prev) + 4) % 4;
                if (m_delta == 2) begin
                    m_err  = 1'b1;
                    m_cnt  = clr_err ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
                    m_prev = m_seen;
                end else begin
                    if (clr_err) begin
                        m_err = 1'b0;
                        m_cnt = 0;
                    end
                    if (m_delta == 1) begin
                        m_pos  = (m_pos + 1) % (1 << POS_W);
                        m_dir  = 1'b1;
                        m_step = 1'b1;
                        m_prev = m_seen;
                    end else if (m_delta == 3) begin
                        m_pos  = (m_pos + (1 << POS_W) - 1) % (1 << POS_W);
                        m_dir  = 1'b0;
                        m_step = 1'b1;
                        m_prev = m_seen;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if ({pos, step, dir, err, err_cnt} !==
                {POS_W'(m_pos), m_step, m_dir, m_err, 4'(m_cnt)}) begin
                bad++;
                $display("FAIL model cyc=%0d: got pos=%0d step=%b dir=%b err=%b cnt=%0d want pos=%0d step=%b dir=%b err=%b cnt=%0d",
                         cyc_no, pos, step, dir, err, err_cnt,
                         m_pos, m_step, m_dir, m_err, m_cnt);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] g);
        res     = 1'b1;
        clr_err = 1'b0;
        gray_in = g;
        cyc(2);
        res = 1'b0;
        cyc(SS + 2);
    endtask

    logic [1:0] seq [4];
    int lat;
    int steps;

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
        res     = 1'b1;
        clr_err = 1'b0;
        gray_in = 2'b10;
        cyc(3);
        chk("rst_pos", int'(pos), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_err", int'(err), 0);
        chk("rst_cnt", int'(err_cnt), 0);

        // Baseline 10 held through reset, then 10 -> 00 -> 01.
        res = 1'b0;
        steps = 0;
        for (int i = 0; i < SS + 2; i++) begin
            cyc(1);
            if (step) steps++;
        end
        chk("warmup_steps", steps, 0);
        gray_in = 2'b00;
        cyc(SS + 3);
        gray_in = 2'b01;
        cyc(SS + 3);
        chk("two_fwd_pos", int'(pos), 2);
        chk("two_fwd_dir", int'(dir), 1);
        chk("two_fwd_err", int'(err), 0);

        // Backward 00 -> 10 from pos 0: sampled at the first edge, step
        // visible after SS further edges.
        do_reset(2'b00);
        gray_in = 2'b10;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            cyc(1);
            if (step) begin
                lat = n;
                break;
            end
        end
        chk("back_latency", lat, SS + 1);
        chk("back_pos", int'(pos), 255);
        chk("back_dir", int'(dir), 0);
        cyc(1);
        chk("back_step_one_cycle", int'(step), 0);

        // 256 forward steps wrap back to 0.
        do_reset(2'b00);
        steps = 0;
        for (int i = 0; i < 256; i++) begin
            gray_in = seq[(i + 1) % 4];
            for (int j = 0; j < 2; j++) begin
                cyc(1);
                if (step) steps++;
            end
        end
        for (int j = 0; j < SS + 2; j++) begin
            cyc(1);
            if (step) steps++;
        end
        chk("walk_steps", steps, 256);
        chk("walk_pos", int'(pos), 0);
        chk("walk_err", int'(err), 0);

        // Seventeen illegal 00 <-> 11 jumps saturate the counter.
        for (int i = 0; i < 17; i++) begin
            gray_in = (i % 2 == 0) ? 2'b11 : 2'b00;
            cyc(2);
        end
        cyc(SS + 2);
        chk("sat_err", int'(err), 1);
        chk("sat_cnt", int'(err_cnt), 15);
        chk("sat_pos", int'(pos), 0);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("clr_err", int'(err), 0);
        chk("clr_cnt", int'(err_cnt), 0);

        // Clear coinciding with an illegal 01 -> 10.
        gray_in = 2'b01;
        cyc(SS + 2);
        gray_in = 2'b10;
        cyc(SS + 2);
        gray_in = 2'b01;
        cyc(SS + 2);
        chk("pre_coinc_cnt", int'(err_cnt), 2);
        gray_in = 2'b10;
        cyc(SS);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("coinc_err", int'(err), 1);
        chk("coinc_cnt", int'(err_cnt), 1);

        // Reset with pos=7, err=1 and clr_err high.
        do_reset(2'b00);
        for (int i = 1; i <= 7; i++) begin
            gray_in = seq[i % 4];
            cyc(2);
        end
        cyc(SS + 1);
        gray_in = 2'b01;
        cyc(SS + 2);
        chk("pre_rst_pos", int'(pos), 7);
        chk("pre_rst_err", int'(err), 1);
        res     = 1'b1;
        clr_err = 1'b1;
        gray_in = 2'b11;
        cyc(1);
        res     = 1'b0;
        clr_err = 1'b0;
        chk("mid_rst_pos", int'(pos), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_cnt", int'(err_cnt), 0);
        chk("mid_rst_dir", int'(dir), 1);
        steps = 0;
        for (int j = 0; j < SS + 2; j++) begin
            cyc(1);
            if (step) steps++;
        end
        chk("mid_rst_no_step", steps, 0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            res     = ($urandom_range(0, 99) < 2);
            clr_err = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) gray_in = 2'($urandom_range(0, 3));
            cyc(1);
        end
        res     = 1'b0;
        clr_err = 1'b0;
        cyc(SS + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
